// File: rtl/mem_lsu_ctrl_pkg.sv
// Shared definitions for the load/store controller: size codes, FSM states, latched request.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package mem_lsu_ctrl_pkg;

    // CPU access size codes; 2'b11 is reserved and always rejected.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Legal range of memory read latency (memread strobe cycle to valid mem_out).
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    // Request fields kept after acceptance. The word address is not stored here:
    // it lives in the mem_dira output register. Only the low half of the store
    // data is needed later, because full-word stores write straight away.
    typedef struct packed {
        logic        is_write;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  addr_lo;
        logic [15:0] wdata;
    } req_t;

    // Misaligned halfword/word or reserved size code.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: load extract with zero/sign extension, and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   word       - 32-bit memory word (read data / old word for merge)
//   addr_lo    - byte offset within the word
//   size       - access size code
//   sext       - sign-extend sub-word loads
//   wdata      - right-justified store data (halfword wide)
//   load_data  - extracted, extended load result
//   store_word - word with the addressed lane(s) replaced by wdata
module mem_lane_align
    import mem_lsu_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Offset 0 is the most significant byte.
    always_comb begin
        lane_b = 8'h00;
        case (addr_lo)
            2'd0:    lane_b = word[31:24];
            2'd1:    lane_b = word[23:16];
            2'd2:    lane_b = word[15:8];
            default: lane_b = word[7:0];
        endcase
        lane_h = addr_lo[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        load_data = 32'h0;
        case (size)
            SZ_BYTE: load_data = {{24{sext & lane_b[7]}}, lane_b};
            SZ_HALF: load_data = {{16{sext & lane_h[15]}}, lane_h};
            SZ_WORD: load_data = word;
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        store_word = word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    store_word[31:24] = wdata[7:0];
                    2'd1:    store_word[23:16] = wdata[7:0];
                    2'd2:    store_word[15:8]  = wdata[7:0];
                    default: store_word[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    store_word[15:0] = wdata;
                end else begin
                    store_word[31:16] = wdata;
                end
            end
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// Load/store controller: turns CPU byte/half/word accesses into word-memory strobes (RMW for sub-word stores).
// Latency: err T+1, word store T+2, load T+2+RD_LAT, sub-word store T+3+RD_LAT (T = accept cycle).
// Backpressure: req_ready only in IDLE, one request in flight; no response backpressure (1-cycle resp_valid pulse).
//
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   req_valid/req_ready     - CPU request handshake
//   req_write/size/signed   - access type
//   req_addr, req_wdata     - byte address, right-justified store data
//   resp_valid/rdata/err    - completion pulse, load data, error flag
//   mem_dira, mem_write_data, mem_memwrite, mem_memread, mem_out - word memory interface
module mem_lsu_ctrl
    import mem_lsu_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [29:0] mem_dira,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_out
);

    // Out-of-range latencies are clamped so the wait counter always terminates.
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam int CNT_W = $clog2(RD_LAT_MAX);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    state_t           state;
    req_t             req_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      ld_data;
    logic [31:0]      st_word;

    // Lane logic sees mem_out directly; its results are only captured into
    // registers on the sampling cycle, so no output is combinational.
    mem_lane_align u_align (
        .word       (mem_out),
        .addr_lo    (req_q.addr_lo),
        .size       (req_q.size),
        .sext       (req_q.sgn),
        .wdata      (req_q.wdata),
        .load_data  (ld_data),
        .store_word (st_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            req_q          <= '0;
            wait_cnt       <= '0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'h0;
            resp_err       <= 1'b0;
            mem_dira       <= 30'h0;
            mem_write_data <= 32'h0;
            mem_memwrite   <= 1'b0;
            mem_memread    <= 1'b0;
        end else begin
            // Strobes and the response are single-cycle pulses: default low,
            // raised only on the transition into the state that owns them.
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_write_data <= 32'h0;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= 32'h0;

            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q <= '{is_write: req_write,
                                   size:     req_size,
                                   sgn:      req_signed,
                                   addr_lo:  req_addr[1:0],
                                   wdata:    req_wdata[15:0]};
                        req_ready <= 1'b0;
                        mem_dira  <= req_addr[31:2];
                        if (req_is_bad(req_size, req_addr[1:0])) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_write && (req_size == SZ_WORD)) begin
                            // Full-word store needs no read of the old word.
                            state          <= ST_WR;
                            mem_memwrite   <= 1'b1;
                            mem_write_data <= req_wdata;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state       <= ST_RD;
                            mem_memread <= 1'b1;
                        end
                    end
                end

                ST_RD: begin
                    state    <= ST_RD_WAIT;
                    wait_cnt <= CNT_INIT;
                end

                ST_RD_WAIT: begin
                    // mem_out is valid in the last RD_WAIT cycle.
                    if (wait_cnt == '0) begin
                        if (req_q.is_write) begin
                            state          <= ST_WR;
                            mem_memwrite   <= 1'b1;
                            mem_write_data <= st_word;
                        end else begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= ld_data;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                ST_WR: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                end

                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_dira  <= 30'h0;
                    req_q     <= '0;
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_dira  <= 30'h0;
                    req_q     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Scoreboard bench for mem_lsu_ctrl with a behavioural word memory (RD_LAT=1).
// Stimulus pushes expected responses/strobe timing; a monitor checks them as the DUT produces them.
// Cycle numbering: cyc increments every rising edge, all observation at the falling edge.
module tb_mem_lsu_ctrl;
    import mem_lsu_ctrl_pkg::*;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [29:0] mem_dira;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_out;

    mem_lsu_ctrl #(.RD_LAT(RD_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_dira       (mem_dira),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_out        (mem_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;       // accept cycle
        int          lat;     // resp_valid cycle offset
        logic [31:0] rdata;
        logic        err;
        int          rd_off;  // memread cycle offset, -1 = none
        int          wr_off;  // memwrite cycle offset, -1 = none
        logic [29:0] dira;
        logic [31:0] wdata;
        logic        resp;    // 0 = transaction will be aborted by reset
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   rd_seen = 0;
    int   wr_seen = 0;
    logic mon_en = 1'b0;

    bit [31:0] mem [bit [29:0]];
    logic        rd_pend = 1'b0;
    logic [29:0] rd_addr = 30'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Behavioural memory: a read strobe in cycle c yields data during cycle c+1
    // only; outside that window mem_out carries a poison value.
    always @(negedge clk) begin
        rd_pend = 1'b0;
        if (!rst) begin
            if (mem_memwrite === 1'b1) mem[mem_dira] = mem_write_data;
            if (mem_memread === 1'b1) begin
                rd_pend = 1'b1;
                rd_addr = mem_dira;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        mem_out = rd_pend ? mem[rd_addr] : 32'hBAD0BAD0;
    end

    // Monitor
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (mem_memwrite !== 1'b1) chk("wdata_quiet", mem_write_data, 32'h0);
            if (mem_memread === 1'b1 || mem_memwrite === 1'b1)
                chk("strobe_excl", {31'b0, mem_memread & mem_memwrite}, 32'h0);
            if (mem_memread === 1'b1) begin
                rd_seen++;
                if (sb.size() == 0) chk("rd_orphan", 32'h1, 32'h0);
                else begin
                    chk("rd_cycle", 32'(cyc - sb[0].t), 32'(sb[0].rd_off));
                    chk("rd_dira", {2'b0, mem_dira}, {2'b0, sb[0].dira});
                end
            end
            if (mem_memwrite === 1'b1) begin
                wr_seen++;
                if (sb.size() == 0) chk("wr_orphan", 32'h1, 32'h0);
                else begin
                    chk("wr_cycle", 32'(cyc - sb[0].t), 32'(sb[0].wr_off));
                    chk("wr_dira", {2'b0, mem_dira}, {2'b0, sb[0].dira});
                    chk("wr_data", mem_write_data, sb[0].wdata);
                end
            end
            if (resp_valid === 1'b1) begin
                if (sb.size() == 0) chk("resp_orphan", 32'h1, 32'h0);
                else begin
                    mon_e = sb.pop_front();
                    chk("resp_expected", {31'b0, mon_e.resp}, 32'h1);
                    chk("resp_lat", 32'(cyc - mon_e.t), 32'(mon_e.lat));
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
                    chk("rd_count", 32'(rd_seen), (mon_e.rd_off >= 0) ? 32'h1 : 32'h0);
                    chk("wr_count", 32'(wr_seen), (mon_e.wr_off >= 0) ? 32'h1 : 32'h0);
                    rd_seen = 0;
                    wr_seen = 0;
                    done_cnt++;
                end
            end
        end
    end

    // Present one request at a falling edge, push its expectation, wait for
    // completion, then confirm the controller is back in IDLE.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input int lat,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int rd_off, input int wr_off, input logic [31:0] exp_wd);
        exp_t e;
        int   n;
        int   start;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before", {31'b0, req_ready}, 32'h1);
        start      = done_cnt;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        e.t = cyc;  e.lat = lat;  e.rdata = exp_rd;  e.err = exp_err;
        e.rd_off = rd_off;  e.wr_off = wr_off;  e.dira = addr[31:2];
        e.wdata = exp_wd;  e.resp = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (done_cnt == start && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("completed", {31'b0, done_cnt != start}, 32'h1);
        if (done_cnt == start) begin
            sb.delete();
            rd_seen = 0;
            wr_seen = 0;
        end
        @(negedge clk);
        chk("ready_after", {31'b0, req_ready}, 32'h1);
        chk("dira_idle", {2'b0, mem_dira}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        exp_t ab;
        int   start;
        rst = 1'b1;  req_valid = 1'b0;  req_write = 1'b0;  req_size = 2'b00;
        req_signed = 1'b0;  req_addr = 32'h0;  req_wdata = 32'h0;
        mem_out = 32'hBAD0BAD0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_dira", {2'b0, mem_dira}, 32'h0);
        chk("rst_strobes", {30'b0, mem_memread, mem_memwrite}, 32'h0);
        chk("rst_wdata", mem_write_data, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Word store
        issue(1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEADBEEF, 2, 32'h0, 1'b0, -1, 1, 32'hDEADBEEF);
        chk("mem_sw", mem[30'h10], 32'hDEADBEEF);

        // Loads from 0x100 = 0x11A23344
        mem[30'h40] = 32'h11A23344;
        issue(1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, 3, 32'hFFFFFFA2, 1'b0, 1, -1, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h101, 32'h0, 3, 32'h000000A2, 1'b0, 1, -1, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h100, 32'h0, 3, 32'h00000011, 1'b0, 1, -1, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 3, 32'h00000044, 1'b0, 1, -1, 32'h0);
        issue(1'b0, SZ_HALF, 1'b1, 32'h100, 32'h0, 3, 32'h000011A2, 1'b0, 1, -1, 32'h0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 3, 32'h11A23344, 1'b0, 1, -1, 32'h0);

        // Halfword store RMW, then signed reload of the new lane
        issue(1'b1, SZ_HALF, 1'b0, 32'h102, 32'h0000BEEF, 4, 32'h0, 1'b0, 1, 3, 32'h11A2BEEF);
        chk("mem_sh", mem[30'h40], 32'h11A2BEEF);
        issue(1'b0, SZ_HALF, 1'b1, 32'h102, 32'h0, 3, 32'hFFFFBEEF, 1'b0, 1, -1, 32'h0);

        // Byte store RMW and follow-up loads
        mem[30'h40] = 32'h11A23344;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h103, 32'hFFFFFF55, 4, 32'h0, 1'b0, 1, 3, 32'h11A23355);
        chk("mem_sb", mem[30'h40], 32'h11A23355);
        issue(1'b0, SZ_HALF, 1'b0, 32'h100, 32'h0, 3, 32'h000011A2, 1'b0, 1, -1, 32'h0);
        issue(1'b1, SZ_BYTE, 1'b0, 32'h100, 32'h000000AB, 4, 32'h0, 1'b0, 1, 3, 32'hABA23355);
        issue(1'b1, SZ_HALF, 1'b0, 32'h100, 32'h1234CAFE, 4, 32'h0, 1'b0, 1, 3, 32'hCAFE3355);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h100, 32'h0, 3, 32'hFFFFFFCA, 1'b0, 1, -1, 32'h0);

        // Errors: no strobes, response at T+1
        issue(1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, 1, 32'h0, 1'b1, -1, -1, 32'h0);
        issue(1'b0, 2'b11,   1'b0, 32'h100, 32'h0, 1, 32'h0, 1'b1, -1, -1, 32'h0);
        issue(1'b1, SZ_HALF, 1'b0, 32'h101, 32'h0000FFFF, 1, 32'h0, 1'b1, -1, -1, 32'h0);
        issue(1'b1, SZ_WORD, 1'b0, 32'h42, 32'h12345678, 1, 32'h0, 1'b1, -1, -1, 32'h0);
        chk("mem_err_untouched", mem[30'h40], 32'hCAFE3355);

        // Reset in the middle of a byte-store RMW (rst high during T+2)
        mem[30'h40] = 32'h11A23344;
        chk("ready_before_abort", {31'b0, req_ready}, 32'h1);
        start      = done_cnt;
        req_valid  = 1'b1;  req_write = 1'b1;  req_size = SZ_BYTE;
        req_signed = 1'b0;  req_addr = 32'h103;  req_wdata = 32'hFFFFFF55;
        ab.t = cyc;  ab.lat = 0;  ab.rdata = 32'h0;  ab.err = 1'b0;
        ab.rd_off = 1;  ab.wr_off = -1;  ab.dira = 30'h40;  ab.wdata = 32'h0;  ab.resp = 1'b0;
        sb.push_back(ab);
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, req_ready}, 32'h1);
        repeat (6) @(negedge clk);
        #2;
        chk("abort_rd", 32'(rd_seen), 32'h1);
        chk("abort_wr", 32'(wr_seen), 32'h0);
        chk("abort_no_resp", 32'(done_cnt - start), 32'h0);
        chk("abort_mem", mem[30'h40], 32'h11A23344);
        sb.delete();
        rd_seen = 0;
        wr_seen = 0;
        @(negedge clk);

        // Top-of-memory addresses
        mem[30'h3FFFFFFF] = 32'hCAFEF00D;
        issue(1'b0, SZ_WORD, 1'b0, 32'hFFFFFFFC, 32'h0, 3, 32'hCAFEF00D, 1'b0, 1, -1, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b0, 32'hFFFFFFFF, 32'h0, 3, 32'h0000000D, 1'b0, 1, -1, 32'h0);
        issue(1'b1, SZ_BYTE, 1'b0, 32'hFFFFFFFE, 32'h00000077, 4, 32'h0, 1'b0, 1, 3, 32'hCAFE770D);
        chk("mem_wrap", mem[30'h3FFFFFFF], 32'hCAFE770D);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
